// File: rtl/gb_mcu_responder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | gb_mcu_responder: CPU memory-bus responder. Serves HRAM and IE locally,   |
// | forwards other addresses over an ext req/ack port with timeout.          |
// | Optional: GB_MCU_ECHO_RAM_EN remaps E000-FDFF to C000-DDFF externally.    |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module gb_mcu_responder #(
  parameter int EXT_TIMEOUT = 255,
  parameter int HRAM_DEPTH  = 127
) (
  input  logic        iClock,
  input  logic        iReset,
  input  logic [15:0] iCpuAddr,
  input  logic [7:0]  iCpuData,
  input  logic        iCpuReadRequest,
  input  logic        iCpuWe,
  output logic [7:0]  oCpuData,
  output logic        oCpuDataValid,
  output logic        oExtReq,
  output logic        oExtWe,
  output logic [15:0] oExtAddr,
  output logic [7:0]  oExtData,
  input  logic [7:0]  iExtData,
  input  logic        iExtAck,
  output logic [7:0]  oIE,
  output logic        oBusError
);
  localparam int         IW        = (HRAM_DEPTH > 1) ? $clog2(HRAM_DEPTH) : 1;
  localparam logic [7:0] C_TMO_LAST = 8'(EXT_TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_EXT_WAIT = 2'd1,
    S_DRAIN    = 2'd2
  } state_t;

  state_t      r_state;
  logic        r_prev_rd;
  logic [7:0]  r_cnt;
  logic        r_ext_rd;
  logic        r_wb_full;
  logic [15:0] r_wb_addr;
  logic [7:0]  r_wb_data;
  logic        r_rp_full;
  logic [15:0] r_rp_addr;
  logic [7:0]  r_hram [HRAM_DEPTH];

  logic          w_rd_edge, w_busy;
  logic          w_iss, w_iss_we, w_wb_take, w_rp_take;
  logic [15:0]   w_iss_addr, w_off;
  logic [7:0]    w_iss_data;
  logic          w_is_hram, w_is_ie, w_is_int;
  logic [IW-1:0] w_idx;
  logic          w_wb_cap, w_wb_drop, w_rp_cap, w_rp_drop, w_wb_nxt, w_rp_nxt;
  logic          w_pend_nxt;

  function automatic logic [15:0] f_ext_addr(input logic [15:0] a);
`ifdef GB_MCU_ECHO_RAM_EN
    if (a >= 16'hE000 && a <= 16'hFDFF) return a - 16'h2000;
`endif
    return a;
  endfunction

  assign w_rd_edge = iCpuReadRequest & ~r_prev_rd;
  assign w_busy    = (r_state != S_IDLE);

  // Pick the access to issue this cycle: live CPU request in IDLE, buffered write before pending read in DRAIN.
  always_comb begin
    w_iss      = 1'b0;
    w_iss_we   = 1'b0;
    w_iss_addr = iCpuAddr;
    w_iss_data = iCpuData;
    w_wb_take  = 1'b0;
    w_rp_take  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (iCpuWe) begin
          w_iss    = 1'b1;
          w_iss_we = 1'b1;
        end else if (w_rd_edge) begin
          w_iss = 1'b1;
        end
      end
      S_DRAIN: begin
        if (r_wb_full) begin
          w_iss      = 1'b1;
          w_iss_we   = 1'b1;
          w_iss_addr = r_wb_addr;
          w_iss_data = r_wb_data;
          w_wb_take  = 1'b1;
        end else if (r_rp_full) begin
          w_iss      = 1'b1;
          w_iss_addr = r_rp_addr;
          w_iss_data = 8'h00;
          w_rp_take  = 1'b1;
        end
      end
      default: ;
    endcase
  end

  assign w_off     = w_iss_addr - 16'hFF80;
  assign w_is_hram = (w_iss_addr >= 16'hFF80) && (32'(w_off) < HRAM_DEPTH);
  assign w_is_ie   = (w_iss_addr == 16'hFFFF);
  assign w_is_int  = w_is_hram | w_is_ie;
  assign w_idx     = w_off[IW-1:0];

  // A slot being drained this cycle may be refilled by a request arriving in the same cycle.
  assign w_wb_cap   = w_busy & iCpuWe;
  assign w_wb_drop  = w_wb_cap & r_wb_full & ~w_wb_take;
  assign w_rp_cap   = w_rd_edge & (w_busy | iCpuWe);
  assign w_rp_drop  = w_rp_cap & r_rp_full & ~w_rp_take;
  assign w_wb_nxt   = (r_wb_full & ~w_wb_take) | w_wb_cap;
  assign w_rp_nxt   = (r_rp_full & ~w_rp_take) | w_rp_cap;
  assign w_pend_nxt = w_wb_nxt | w_rp_nxt;

  always_ff @(posedge iClock) begin
    if (!iReset && w_iss && w_iss_we && w_is_hram) r_hram[w_idx] <= w_iss_data;
  end

  always_ff @(posedge iClock) begin
    if (iReset) begin
      r_state       <= S_IDLE;
      r_prev_rd     <= 1'b0;
      r_cnt         <= 8'd0;
      r_ext_rd      <= 1'b0;
      r_wb_full     <= 1'b0;
      r_wb_addr     <= 16'h0000;
      r_wb_data     <= 8'h00;
      r_rp_full     <= 1'b0;
      r_rp_addr     <= 16'h0000;
      oCpuData      <= 8'hFF;
      oCpuDataValid <= 1'b0;
      oExtReq       <= 1'b0;
      oExtWe        <= 1'b0;
      oExtAddr      <= 16'h0000;
      oExtData      <= 8'h00;
      oIE           <= 8'h00;
      oBusError     <= 1'b0;
    end else begin
      r_prev_rd     <= iCpuReadRequest;
      oCpuDataValid <= 1'b0;
      r_wb_full     <= w_wb_nxt;
      r_rp_full     <= w_rp_nxt;
      if (w_wb_drop | w_rp_drop) oBusError <= 1'b1;
      if (w_wb_cap & ~w_wb_drop) begin
        r_wb_addr <= iCpuAddr;
        r_wb_data <= iCpuData;
      end
      if (w_rp_cap & ~w_rp_drop) r_rp_addr <= iCpuAddr;

      case (r_state)
        S_IDLE, S_DRAIN: begin
          if (w_iss && !w_is_int) begin
            oExtReq  <= 1'b1;
            oExtWe   <= w_iss_we;
            oExtAddr <= f_ext_addr(w_iss_addr);
            oExtData <= w_iss_data;
            r_ext_rd <= ~w_iss_we;
            r_cnt    <= 8'd0;
            r_state  <= S_EXT_WAIT;
          end else begin
            if (w_iss) begin
              if (w_iss_we) begin
                if (w_is_ie) oIE <= w_iss_data;
              end else begin
                oCpuData      <= w_is_ie ? oIE : r_hram[w_idx];
                oCpuDataValid <= 1'b1;
              end
            end
            r_state <= w_pend_nxt ? S_DRAIN : S_IDLE;
          end
        end
        S_EXT_WAIT: begin
          if (iExtAck) begin
            oExtReq <= 1'b0;
            if (r_ext_rd) begin
              oCpuData      <= iExtData;
              oCpuDataValid <= 1'b1;
            end
            r_state <= w_pend_nxt ? S_DRAIN : S_IDLE;
          end else if (r_cnt == C_TMO_LAST) begin
            oExtReq   <= 1'b0;
            oBusError <= 1'b1;
            if (r_ext_rd) begin
              oCpuData      <= 8'hFF;
              oCpuDataValid <= 1'b1;
            end
            r_state <= w_pend_nxt ? S_DRAIN : S_IDLE;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule
`default_nettype wire

// File: tb/tb_gb_mcu_responder.sv
`default_nettype none
// Directed bench for gb_mcu_responder: table-driven internal accesses plus
// hand-written external, timeout, buffering, reset and echo sequences.
module tb_gb_mcu_responder;
  logic        clk;
  logic        rst;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_wdata;
  logic        cpu_rd;
  logic        cpu_we;
  logic [7:0]  cpu_rdata;
  logic        cpu_valid;
  logic        ext_req;
  logic        ext_we;
  logic [15:0] ext_addr;
  logic [7:0]  ext_wdata;
  logic [7:0]  ext_rdata;
  logic        ext_ack;
  logic [7:0]  ie;
  logic        bus_err;

  int n_chk;
  int n_err;

  gb_mcu_responder #(.EXT_TIMEOUT(4), .HRAM_DEPTH(127)) dut (
    .iClock(clk), .iReset(rst),
    .iCpuAddr(cpu_addr), .iCpuData(cpu_wdata),
    .iCpuReadRequest(cpu_rd), .iCpuWe(cpu_we),
    .oCpuData(cpu_rdata), .oCpuDataValid(cpu_valid),
    .oExtReq(ext_req), .oExtWe(ext_we), .oExtAddr(ext_addr), .oExtData(ext_wdata),
    .iExtData(ext_rdata), .iExtAck(ext_ack),
    .oIE(ie), .oBusError(bus_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic        we;
    logic        rd;
    logic [15:0] addr;
    logic [7:0]  data;
    logic        exp_v;
    logic [7:0]  exp_d;
    logic [7:0]  exp_ie;
  } vec_t;

  vec_t vecs [9];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [15:0] got, input logic [15:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  initial begin
    n_chk = 0;
    n_err = 0;
    vecs[0] = '{1'b1, 1'b0, 16'hFF85, 8'h3C, 1'b0, 8'hFF, 8'h00};
    vecs[1] = '{1'b0, 1'b1, 16'hFF85, 8'h00, 1'b1, 8'h3C, 8'h00};
    vecs[2] = '{1'b1, 1'b0, 16'hFFFF, 8'h1F, 1'b0, 8'h3C, 8'h1F};
    vecs[3] = '{1'b0, 1'b1, 16'hFFFF, 8'h00, 1'b1, 8'h1F, 8'h1F};
    vecs[4] = '{1'b1, 1'b0, 16'hFFFE, 8'hA0, 1'b0, 8'h1F, 8'h1F};
    vecs[5] = '{1'b0, 1'b1, 16'hFFFE, 8'h00, 1'b1, 8'hA0, 8'h1F};
    vecs[6] = '{1'b1, 1'b0, 16'hFF80, 8'h5A, 1'b0, 8'hA0, 8'h1F};
    vecs[7] = '{1'b0, 1'b1, 16'hFF80, 8'h00, 1'b1, 8'h5A, 8'h1F};
    vecs[8] = '{1'b0, 1'b1, 16'hFF85, 8'h00, 1'b1, 8'h3C, 8'h1F};

    rst = 1'b1; cpu_addr = 16'h0; cpu_wdata = 8'h0; cpu_rd = 1'b0; cpu_we = 1'b0;
    ext_rdata = 8'h0; ext_ack = 1'b0;
    tick(); tick();
    chk("rst_data", 16'(cpu_rdata), 16'h00FF);
    chk("rst_valid", 16'(cpu_valid), 16'h0);
    chk("rst_req", 16'(ext_req), 16'h0);
    chk("rst_addr", ext_addr, 16'h0);
    chk("rst_ie", 16'(ie), 16'h0);
    chk("rst_err", 16'(bus_err), 16'h0);
    rst = 1'b0;
    tick();

    // Internal HRAM / IE accesses, each followed by an idle cycle
    for (int i = 0; i < 9; i++) begin
      cpu_we = vecs[i].we; cpu_rd = vecs[i].rd;
      cpu_addr = vecs[i].addr; cpu_wdata = vecs[i].data;
      tick();
      chk($sformatf("vec%0d_valid", i), 16'(cpu_valid), 16'(vecs[i].exp_v));
      chk($sformatf("vec%0d_data", i), 16'(cpu_rdata), 16'(vecs[i].exp_d));
      chk($sformatf("vec%0d_ie", i), 16'(ie), 16'(vecs[i].exp_ie));
      chk($sformatf("vec%0d_req", i), 16'(ext_req), 16'h0);
      cpu_we = 1'b0; cpu_rd = 1'b0;
      tick();
      chk($sformatf("vec%0d_idle_valid", i), 16'(cpu_valid), 16'h0);
    end

    // External read with ack three cycles after request
    cpu_rd = 1'b1; cpu_addr = 16'hC123;
    tick();
    chk("ext_req_hi", 16'(ext_req), 16'h1);
    chk("ext_addr", ext_addr, 16'hC123);
    chk("ext_we_rd", 16'(ext_we), 16'h0);
    cpu_rd = 1'b0;
    tick();
    chk("ext_wait1_req", 16'(ext_req), 16'h1);
    chk("ext_wait1_valid", 16'(cpu_valid), 16'h0);
    tick();
    chk("ext_wait2_req", 16'(ext_req), 16'h1);
    ext_ack = 1'b1; ext_rdata = 8'hA5;
    tick();
    chk("ext_ack_req", 16'(ext_req), 16'h0);
    chk("ext_ack_valid", 16'(cpu_valid), 16'h1);
    chk("ext_ack_data", 16'(cpu_rdata), 16'h00A5);
    ext_ack = 1'b0;
    tick();
    chk("ext_single_pulse", 16'(cpu_valid), 16'h0);
    chk("ext_err_clear", 16'(bus_err), 16'h0);

    // Timeout with EXT_TIMEOUT=4
    cpu_rd = 1'b1; cpu_addr = 16'h8000;
    tick();
    chk("tmo_req_hi", 16'(ext_req), 16'h1);
    cpu_rd = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      tick();
      chk($sformatf("tmo_req_hold%0d", k), 16'(ext_req), 16'h1);
    end
    tick();
    chk("tmo_req_drop", 16'(ext_req), 16'h0);
    chk("tmo_data", 16'(cpu_rdata), 16'h00FF);
    chk("tmo_valid", 16'(cpu_valid), 16'h1);
    chk("tmo_err", 16'(bus_err), 16'h1);
    ext_ack = 1'b1; ext_rdata = 8'h12;
    tick();
    chk("stray_ack_valid", 16'(cpu_valid), 16'h0);
    chk("stray_ack_data", 16'(cpu_rdata), 16'h00FF);
    ext_ack = 1'b0;
    tick(); tick();
    chk("tmo_err_sticky", 16'(bus_err), 16'h1);

    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst2_err", 16'(bus_err), 16'h0);
    tick();

    // Buffered write and pending read during an external read
    cpu_we = 1'b1; cpu_addr = 16'hFF80; cpu_wdata = 8'h66;
    tick();
    cpu_we = 1'b0;
    cpu_rd = 1'b1; cpu_addr = 16'hC000;
    tick();
    chk("buf_req", 16'(ext_req), 16'h1);
    chk("buf_addr0", ext_addr, 16'hC000);
    cpu_rd = 1'b0; cpu_we = 1'b1; cpu_addr = 16'hD000; cpu_wdata = 8'h55;
    tick();
    chk("buf_wb_noerr", 16'(bus_err), 16'h0);
    cpu_we = 1'b0; cpu_rd = 1'b1; cpu_addr = 16'hFF80;
    tick();
    cpu_rd = 1'b0; cpu_we = 1'b1; cpu_addr = 16'hD100; cpu_wdata = 8'h99;
    tick();
    chk("buf_overflow_err", 16'(bus_err), 16'h1);
    cpu_we = 1'b0;
    ext_ack = 1'b1; ext_rdata = 8'h3E;
    tick();
    chk("buf_rd_valid", 16'(cpu_valid), 16'h1);
    chk("buf_rd_data", 16'(cpu_rdata), 16'h003E);
    chk("buf_rd_req_lo", 16'(ext_req), 16'h0);
    ext_ack = 1'b0;
    tick();
    chk("drain_wr_req", 16'(ext_req), 16'h1);
    chk("drain_wr_addr", ext_addr, 16'hD000);
    chk("drain_wr_we", 16'(ext_we), 16'h1);
    chk("drain_wr_data", 16'(ext_wdata), 16'h0055);
    ext_ack = 1'b1;
    tick();
    chk("drain_wr_done", 16'(ext_req), 16'h0);
    chk("drain_wr_novalid", 16'(cpu_valid), 16'h0);
    ext_ack = 1'b0;
    tick();
    chk("drain_rd_valid", 16'(cpu_valid), 16'h1);
    chk("drain_rd_data", 16'(cpu_rdata), 16'h0066);
    chk("drain_rd_noext", 16'(ext_req), 16'h0);
    tick();
    chk("drain_idle_valid", 16'(cpu_valid), 16'h0);
    chk("drain_idle_req", 16'(ext_req), 16'h0);

    // Simultaneous write and read edge in IDLE
    cpu_we = 1'b1; cpu_rd = 1'b1; cpu_addr = 16'hFF90; cpu_wdata = 8'h77;
    tick();
    chk("simul_wr_novalid", 16'(cpu_valid), 16'h0);
    cpu_we = 1'b0; cpu_rd = 1'b0;
    tick();
    chk("simul_rd_valid", 16'(cpu_valid), 16'h1);
    chk("simul_rd_data", 16'(cpu_rdata), 16'h0077);
    tick();

    // Reset during EXT_WAIT
    cpu_rd = 1'b1; cpu_addr = 16'h4000;
    tick();
    chk("rstw_req_hi", 16'(ext_req), 16'h1);
    cpu_rd = 1'b0; rst = 1'b1;
    tick();
    chk("rstw_req", 16'(ext_req), 16'h0);
    chk("rstw_data", 16'(cpu_rdata), 16'h00FF);
    chk("rstw_ie", 16'(ie), 16'h0);
    chk("rstw_err", 16'(bus_err), 16'h0);
    chk("rstw_addr", ext_addr, 16'h0);
    rst = 1'b0;
    tick(); tick();
    chk("rstw_after_req", 16'(ext_req), 16'h0);
    chk("rstw_after_valid", 16'(cpu_valid), 16'h0);

    // Echo RAM address mapping
    cpu_rd = 1'b1; cpu_addr = 16'hE010;
    tick();
    cpu_rd = 1'b0;
`ifdef GB_MCU_ECHO_RAM_EN
    chk("echo_addr", ext_addr, 16'hC010);
`else
    chk("echo_addr", ext_addr, 16'hE010);
`endif
    ext_ack = 1'b1; ext_rdata = 8'h42;
    tick();
    chk("echo_data", 16'(cpu_rdata), 16'h0042);
    ext_ack = 1'b0;
    tick();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/gb_mcu_responder.md
Name: gb_mcu_responder

Overview:
- Memory-side responder for the CPU memory bus: accepts CPU read requests and write strobes and returns read data.
- Serves high RAM (FF80–FFFE) and the IE register (FFFF) internally.
- Forwards all other addresses to the external memory/peripheral port using a req/ack handshake with a timeout.
- Sits between the CPU core and the cartridge/VRAM/WRAM/IO fabric.

Parameters:
EXT_TIMEOUT, 255, cycles to wait for iExtAck before aborting an external access (8-bit counter; valid range 1–255)
HRAM_DEPTH, 127, number of internal HRAM bytes, mapped at FF80 upward

Ports:
iClock  in  1  system clock
iReset  in  1  synchronous active-high reset
iCpuAddr  in  16  CPU address
iCpuData  in  8  CPU write data
iCpuReadRequest  in  1  level read request (registered at the CPU)
iCpuWe  in  1  write strobe; one write per cycle it is high
oCpuData  out  8  read data; holds the last completed read
oCpuDataValid  out  1  one-cycle pulse when oCpuData updates
oExtReq  out  1  external access request
oExtWe  out  1  external write qualifier
oExtAddr  out  16  external address
oExtData  out  8  external write data
iExtData  in  8  external read data, valid with iExtAck
iExtAck  in  1  external completion
oIE  out  8  interrupt-enable register (FFFF)
oBusError  out  1  sticky error flag

Behaviour:
- Clock and reset: single clock iClock. Reset iReset is synchronous and active-high.
- Reset values:
  - oCpuData=8'hFF; oCpuDataValid=0; oExtReq=0; oExtWe=0; oExtAddr=0; oExtData=0; oIE=0; oBusError=0.
  - State=IDLE; both pending slots are empty.
  - HRAM contents are not reset.
- Read start: a read starts on the rising edge of iCpuReadRequest (sampled high now, low on the previous cycle). The address is captured at that edge.
- States:
  - IDLE
  - EXT_WAIT: external access in flight.
  - DRAIN: issue the buffered write or the pending read.
- IDLE, internal read: oCpuData updates at the next edge; oCpuDataValid pulses that cycle. Latency is 1 cycle.
- IDLE, internal write (iCpuWe=1): HRAM/IE is committed at that edge. No response pulse.
- IDLE, external access:
  - Next cycle: oExtReq=1, oExtAddr=captured address, oExtWe=iCpuWe, oExtData=iCpuData. State becomes EXT_WAIT.
  - oExtReq/oExtAddr/oExtWe/oExtData stay stable until ack.
- EXT_WAIT:
  - On the edge where iExtAck=1: oExtReq<=0. For a read, oCpuData<=iExtData and oCpuDataValid<=1.
  - Next state is DRAIN if any pending slot is full, otherwise IDLE.
  - A read (latency ≥2 cycles) or write (≥1 cycle of bus occupancy after its strobe) cannot complete faster than that.
- Timeout: when the counter reaches EXT_TIMEOUT without ack, the access is aborted: oExtReq<=0 and oBusError<=1. For a read, oCpuData<=8'hFF and oCpuDataValid pulses. The counter resets on every new access.
- Requests while busy (EXT_WAIT or DRAIN):
  - iCpuWe captures address/data into a 1-entry write buffer.
  - A read edge sets the 1-entry read-pending slot.
  - A second write or read arriving while its slot is full is dropped and sets oBusError.
- DRAIN order: the buffered write is issued before the pending read. Each is issued by the same rules as IDLE: internal completes in 1 cycle, external goes to EXT_WAIT.
- Simultaneous iCpuWe and read edge in IDLE: the write is served, and the read goes to the pending slot.
- iExtAck while oExtReq=0 is ignored.
- Address decode:
  - FF80..FF80+HRAM_DEPTH-1 → HRAM.
  - FFFF → IE.
  - Otherwise external.
- oBusError is cleared only by reset.
- Reset mid-access drops oExtReq on the next edge and empties both pending slots.

Optional Feature:
GB_MCU_ECHO_RAM_EN:
- Defined: addresses E000–FDFF are presented on oExtAddr as addr−16'h2000 (WRAM echo), for both reads and writes.
- Undefined: the address is passed unchanged.

Test Plan:
- Write FF85=8'h3C, then read-request edge FF85 → oCpuData=8'h3C with oCpuDataValid one cycle after the edge. Write FFFF=8'h1F → oIE=8'h1F next cycle.
- Read C123, ext acks 3 cycles after oExtReq with iExtData=8'hA5 → oExtAddr=C123, oExtWe=0, oCpuData=8'hA5, single valid pulse.
- Read 8000, no ack, EXT_TIMEOUT=4 → oExtReq drops after 4 cycles, oCpuData=8'hFF, oBusError=1 and stays 1.
- During ext read C000, write D000=8'h55 then read edge FF80 → after ack: ext write D000/55 issued, then HRAM read completes. A third write while the buffer is full → oBusError=1.
- Simultaneous iCpuWe (FF90=8'h77) and read edge FF90 in IDLE → write first, then read returns 8'h77. iReset during EXT_WAIT → oExtReq=0 next cycle, all outputs at reset values.
- With GB_MCU_ECHO_RAM_EN: read E010 → oExtAddr=C010. Without the macro → oExtAddr=E010.
